// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART bridge: RX/TX byte FIFOs, cycle/instret counters
// and sticky error flags at region 0x8000_0000.
module uart_mmio_fifo #(
    parameter int RX_DEPTH = 8,
    parameter int TX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    input  logic        instr_retire,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam logic [RAW:0] RX_FULL = (RAW+1)'(RX_DEPTH);
    localparam logic [TAW:0] TX_FULL = (TAW+1)'(TX_DEPTH);

    localparam logic [2:0] OFF_RXC  = 3'd0;
    localparam logic [2:0] OFF_RXD  = 3'd1;
    localparam logic [2:0] OFF_TXC  = 3'd2;
    localparam logic [2:0] OFF_TXD  = 3'd3;
    localparam logic [2:0] OFF_CYC  = 3'd4;
    localparam logic [2:0] OFF_INS  = 3'd5;
    localparam logic [2:0] OFF_CRST = 3'd6;
    localparam logic [2:0] OFF_STAT = 3'd7;

    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_wp_q, rx_wp_d;
    logic [RAW-1:0] rx_rp_q, rx_rp_d;
    logic [RAW:0]   rx_cnt_q, rx_cnt_d;

    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TAW-1:0] tx_wp_q, tx_wp_d;
    logic [TAW-1:0] tx_rp_q, tx_rp_d;
    logic [TAW:0]   tx_cnt_q, tx_cnt_d;

    logic [31:0] rdata_q, rdata_d;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] ins_q, ins_d;
    logic        rx_unf_q, rx_unf_d;
    logic        tx_ovf_q, tx_ovf_d;

    logic       active, rd_act, wr_act;
    logic [2:0] off;
    logic       rx_empty, rx_full, tx_empty, tx_full;
    logic       rx_push, rx_pop, rx_pop_req;
    logic       tx_push, tx_pop, tx_push_req;
    logic       unf_set, ovf_set, stat_clr, cnt_clr;
    logic [7:0] rx_head;

    assign hit    = (addr[31:28] == 4'h8) && (addr[27:5] == 23'd0);
    assign active = hit && !stall && (re || we);
    assign rd_act = active && re;
    assign wr_act = active && we;
    assign off    = addr[4:2];

    // Full/empty come from the start-of-cycle counts, so a same-cycle
    // UART push/pop never rescues a rejected CPU access.
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == RX_FULL);
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == TX_FULL);

    assign rx_ready = !rx_full;
    assign tx_valid = !tx_empty;
    assign rx_head  = rx_empty ? 8'h00 : rx_mem[rx_rp_q];
    assign tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rp_q];

    assign rx_push     = rx_valid && rx_ready;
    assign rx_pop_req  = rd_act && (off == OFF_RXD);
    assign rx_pop      = rx_pop_req && !rx_empty;
    assign unf_set     = rx_pop_req && rx_empty;

    assign tx_pop      = tx_valid && tx_ready;
    assign tx_push_req = wr_act && (off == OFF_TXD);
    assign tx_push     = tx_push_req && !tx_full;
    assign ovf_set     = tx_push_req && tx_full;

    assign stat_clr = wr_act && (off == OFF_STAT);
    assign cnt_clr  = wr_act && (off == OFF_CRST);

    always_comb begin
        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        rx_cnt_d = rx_cnt_q;
        if (rx_push) rx_wp_d = rx_wp_q + RAW'(1);
        if (rx_pop)  rx_rp_d = rx_rp_q + RAW'(1);
        unique case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + (RAW+1)'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - (RAW+1)'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    always_comb begin
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_push) tx_wp_d = tx_wp_q + TAW'(1);
        if (tx_pop)  tx_rp_d = tx_rp_q + TAW'(1);
        unique case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + (TAW+1)'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - (TAW+1)'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    always_comb begin
        cyc_d = cyc_q + 32'd1;
        ins_d = ins_q;
        if (instr_retire && !stall) ins_d = ins_q + 32'd1;
        if (cnt_clr) begin
            cyc_d = '0;
            ins_d = '0;
        end
        // Set wins over a same-cycle clear.
        rx_unf_d = (rx_unf_q && !stat_clr) || unf_set;
        tx_ovf_d = (tx_ovf_q && !stat_clr) || ovf_set;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_act) begin
            unique case (off)
                OFF_RXC:  rdata_d = {31'd0, !rx_empty};
                OFF_RXD:  rdata_d = {24'd0, rx_head};
                OFF_TXC:  rdata_d = {31'd0, !tx_full};
                OFF_CYC:  rdata_d = cyc_q;
                OFF_INS:  rdata_d = ins_q;
                OFF_STAT: rdata_d = {16'(rx_cnt_q), 14'(tx_cnt_q),
                                     tx_ovf_q, rx_unf_q};
                default:  rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rdata_q  <= '0;
            cyc_q    <= '0;
            ins_q    <= '0;
            rx_unf_q <= 1'b0;
            tx_ovf_q <= 1'b0;
        end else begin
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            rx_cnt_q <= rx_cnt_d;
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            tx_cnt_q <= tx_cnt_d;
            rdata_q  <= rdata_d;
            cyc_q    <= cyc_d;
            ins_q    <= ins_d;
            rx_unf_q <= rx_unf_d;
            tx_ovf_q <= tx_ovf_d;
        end
    end

    // Storage needs no reset; pointers and counts define validity.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp_q] <= rx_data;
        if (tx_push) tx_mem[tx_wp_q] <= wdata[7:0];
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Scoreboard bench for uart_mmio_fifo: loads and TX bytes are queued as
// expected values at issue time and checked by independent monitors.
module tb_uart_mmio_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] addr = 32'h8000_0000;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        hit;
    logic        instr_retire = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [31:0] ld_q [$];
    logic [7:0]  tx_q [$];
    logic        chk_pend = 1'b0;

    uart_mmio_fifo #(.RX_DEPTH(4), .TX_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .stall(stall), .addr(addr),
        .re(re), .we(we), .wdata(wdata), .rdata(rdata), .hit(hit),
        .instr_retire(instr_retire), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Load monitor: an accepted load shows on rdata after the edge.
    always @(posedge clk)
        chk_pend <= !rst && re && !stall && addr[31:28] == 4'h8
                    && addr[27:5] == 23'd0;

    always @(negedge clk) begin
        if (chk_pend) begin
            if (ld_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL load_sb: unexpected load result 0x%08h", rdata);
            end else begin
                check("load", rdata, ld_q.pop_front());
            end
        end
    end

    // TX monitor: every accepted handshake pops one expected byte.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            if (tx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_sb: unexpected byte 0x%02h", tx_data);
            end else begin
                check("tx_data", {24'd0, tx_data}, {24'd0, tx_q.pop_front()});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [2:0] off, input logic [31:0] exp);
        addr = 32'h8000_0000 | {27'd0, off, 2'b00};
        re = 1'b1;
        ld_q.push_back(exp);
        cyc();
        re = 1'b0;
    endtask

    task automatic st(input logic [2:0] off, input logic [31:0] d);
        addr = 32'h8000_0000 | {27'd0, off, 2'b00};
        wdata = d;
        we = 1'b1;
        cyc();
        we = 1'b0;
    endtask

    task automatic drain_tx();
        int n;
        n = 0;
        tx_ready = 1'b1;
        while (tx_valid && n < 20) begin
            cyc();
            n++;
        end
        tx_ready = 1'b0;
        check("tx_drain_valid", {31'd0, tx_valid}, 32'd0);
        check("tx_drain_left", tx_q.size(), 32'd0);
    endtask

    initial begin
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        check("rst_rdata", rdata, 32'd0);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        ld(3'd0, 32'h0);
        ld(3'd2, 32'h1);
        ld(3'd7, 32'h0);

        // RX ordering and underflow
        rx_valid = 1'b1;
        rx_data = 8'h41; cyc();
        rx_data = 8'h42; cyc();
        rx_data = 8'h43; cyc();
        rx_valid = 1'b0;
        ld(3'd0, 32'h1);
        ld(3'd1, 32'h41);
        ld(3'd1, 32'h42);
        ld(3'd1, 32'h43);
        ld(3'd1, 32'h0);
        ld(3'd7, 32'h1);
        st(3'd7, 32'h0);
        ld(3'd7, 32'h0);

        // TX fill past full with transmitter blocked
        for (int i = 0; i < 9; i++) begin
            st(3'd3, 32'h10 + i);
            if (i < 8) tx_q.push_back(8'(8'h10 + i));
        end
        ld(3'd7, 32'h22);
        ld(3'd2, 32'h0);
        drain_tx();
        st(3'd7, 32'h0);

        // Push and pop on a one-entry TX FIFO: new byte becomes head
        st(3'd3, 32'hA1);
        tx_q.push_back(8'hA1);
        tx_ready = 1'b1;
        st(3'd3, 32'hA2);
        tx_q.push_back(8'hA2);
        tx_ready = 1'b0;
        ld(3'd7, 32'h4);
        drain_tx();

        // Stalled load: rdata holds, one pop on release
        rx_valid = 1'b1;
        rx_data = 8'h55; cyc();
        rx_data = 8'h66; cyc();
        rx_valid = 1'b0;
        ld(3'd7, 32'h0002_0000);
        stall = 1'b1;
        re = 1'b1;
        addr = 32'h8000_0004;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("stall_hold", rdata, 32'h0002_0000);
        end
        stall = 1'b0;
        ld(3'd1, 32'h55);
        ld(3'd7, 32'h0001_0000);
        ld(3'd1, 32'h66);

        // Retire counter with stalls, then reset racing an increment
        st(3'd6, 32'h0);
        instr_retire = 1'b1;
        repeat (5) cyc();
        stall = 1'b1;
        repeat (2) cyc();
        stall = 1'b0;
        instr_retire = 1'b0;
        ld(3'd5, 32'd5);
        instr_retire = 1'b1;
        st(3'd6, 32'h0);
        instr_retire = 1'b0;
        ld(3'd4, 32'd0);
        ld(3'd5, 32'd0);
        ld(3'd4, 32'd2);

        // RX push and pop every cycle across pointer wrap
        rx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rx_data = 8'(8'h80 + i);
            if (i > 0) begin
                addr = 32'h8000_0004;
                re = 1'b1;
                ld_q.push_back(32'h80 + i - 1);
            end
            check("rx_ready_hold", {31'd0, rx_ready}, 32'd1);
            cyc();
        end
        rx_valid = 1'b0;
        re = 1'b0;
        ld(3'd1, 32'h93);
        ld(3'd0, 32'h0);

        repeat (3) cyc();
        check("ld_q_empty", ld_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
